// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of the shared MIPS16e ALU.
// Define ALU_ARB_RR_EN for round-robin ties; default is fixed priority (req1 wins).
module alu_arbiter #(
   parameter int word_size = 16,
   parameter int op_size   = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [op_size-1:0]   op0,
   input  logic [op_size-1:0]   op1,
   input  logic [word_size-1:0] x0,
   input  logic [word_size-1:0] y0,
   input  logic [word_size-1:0] x1,
   input  logic [word_size-1:0] y1,
   input  logic                 flush0,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 done0,
   output logic                 done1,
   output logic [word_size-1:0] result,
   output logic                 result_zero,
   output logic                 busy,
   output logic [op_size-1:0]   alu_op,
   output logic [word_size-1:0] alu_x,
   output logic [word_size-1:0] alu_y,
   input  logic [word_size-1:0] alu_out,
   input  logic                 alu_zero
);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t state;
   logic   owner;
   logic   last;
   logic   pick1;
   logic   kill;

   // Winner for the IDLE edge: 1 selects requester 1
   always_comb begin
`ifdef ALU_ARB_RR_EN
      pick1 = req1 & (~req0 | ~last);
`else
      // last never changes the fixed-priority outcome
      pick1 = req1 | (req0 & req1 & last);
`endif
   end

   // A flushed requester-0 operation must not publish its result
   always_comb begin
      kill = flush0 & ~owner;
   end

   // Sequencer: grant and latch in IDLE, capture result in EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last        <= 1'b1;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         result      <= '0;
         result_zero <= 1'b1;
         busy        <= 1'b0;
         alu_op      <= '0;
         alu_x       <= '0;
         alu_y       <= '0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req0 | req1) begin
                  owner  <= pick1;
                  last   <= pick1;
                  gnt0   <= ~pick1;
                  gnt1   <= pick1;
                  alu_op <= pick1 ? op1 : op0;
                  alu_x  <= pick1 ? x1 : x0;
                  alu_y  <= pick1 ? y1 : y0;
                  busy   <= 1'b1;
                  state  <= EXEC;
               end else begin
                  alu_op <= '0;
                  alu_x  <= '0;
                  alu_y  <= '0;
               end
            end
            EXEC: begin
               if (!kill) begin
                  result      <= alu_out;
                  result_zero <= alu_zero;
                  done0       <= ~owner;
                  done1       <= owner;
               end
               alu_op <= '0;
               alu_x  <= '0;
               alu_y  <= '0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 16-bit ALU of the MIPS16e core. It lets the execute stage (requester 0) and the exception/interrupt unit (requester 1) share one ALU instance. For each operation it arbitrates between the requesters, latches the operands, drives the ALU for one cycle and returns a registered result and zero flag. The block sits between those two units and the ALU's `op_type`/`data_x`/`data_y` inputs and `alu_out`/`alu_zero_flag` outputs.

## Interface
- `word_size`, 16, datapath width
- `op_size`, 6, ALU opcode width
- `clk` input 1 system clock, rising edge
- `rst` input 1 reset, asynchronous, active-high
- `req0`, `req1` input 1 each: operation request, level
- `op0`, `op1` input `op_size` each: opcode, valid while the matching req is high
- `x0`, `y0`, `x1`, `y1` input `word_size`: operands, valid while the matching req is high
- `flush0` input 1 aborts the requester-0 operation in flight
- `gnt0`, `gnt1` output 1 one-cycle pulse: operands accepted
- `done0`, `done1` output 1 one-cycle pulse: result valid
- `result` output `word_size` last captured ALU result
- `result_zero` output 1 last captured ALU zero flag
- `busy` output 1 high when state ≠ IDLE
- `alu_op` output `op_size` to ALU `op_type`
- `alu_x`, `alu_y` output `word_size` to ALU `data_x`/`data_y`
- `alu_out` input `word_size` from ALU
- `alu_zero` input 1 from ALU `alu_zero_flag`

## Operation
- FSM with 2 states: IDLE, EXEC.
- IDLE: if any req is high at the clock edge, arbitrate, latch the winner's op/x/y into `alu_op`/`alu_x`/`alu_y`, set `owner`, pulse that requester's gnt, and go to EXEC. Otherwise stay; `alu_op`=0, `alu_x`=`alu_y`=0.
- EXEC: the ALU is combinational. At the edge, capture `alu_out`→`result` and `alu_zero`→`result_zero`, pulse `done<owner>`, clear `alu_op`/`alu_x`/`alu_y` to 0, and return to IDLE. Req inputs are ignored in EXEC.
- Requester protocol: drop req on the edge after gnt is seen, or keep it high to request again. A req still high in IDLE is a new operation.
- `result`/`result_zero` hold until the next capture.
- Flush: if `flush0` is high at the EXEC edge and `owner`=0, `done0` is suppressed and `result`/`result_zero` are not updated; the FSM still returns to IDLE. `flush0` in IDLE does not block a grant. `flush0` has no effect when `owner`=1.
- Arbitration: fixed priority or round-robin (see Configuration). `last` pointer records the most recent grant.
- No arithmetic is done in this block. Widths pass through unchanged.

## Timing
- Reset values: state=IDLE, `gnt0`=`gnt1`=`done0`=`done1`=0, `result`=0, `result_zero`=1, `alu_op`=`alu_x`=`alu_y`=0, `busy`=0, `last`=1 (requester 0 wins the first tie).
- Latency: req sampled at edge E0 → gnt high in cycle E0–E1 → done and result valid in cycle E1–E2.
- Throughput: one operation per 2 cycles. Next sampling edge is E2.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-EXEC: the operation is dropped, no done pulse, all outputs return to reset values immediately.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. On a tie, grant the requester ≠ `last`. `last` updates on every grant.
- Undefined: fixed priority, requester 1 always wins ties. `last` is still maintained but ignored.

## Test plan
- Reset: `rst`=1 mid-EXEC → next cycle `busy`=0, `result`=0, `result_zero`=1, no done pulse.
- Single op: `req0`=1, `op0`=5, `x0`=16'h0003, `y0`=16'h0004 for one edge, ALU model returns x+y → `gnt0` one cycle later, `done0` next, `result`=16'h0007, `result_zero`=0.
- Zero result: `req1`, ALU model returns 0 → `done1` pulse, `result_zero`=1.
- Tie, RR build: `req0`=`req1`=1 held for 4 operations → grant order 0,1,0,1. Fixed build → 1,1,1,1.
- Back-to-back: `req0` held high → `gnt0` every 2nd cycle, `busy` high 1 of every 2 cycles.
- Flush: `flush0`=1 during EXEC with `owner`=0, `result` previously 16'h00AA → no `done0`, `result` stays 16'h00AA. Same with `owner`=1 → `done1` asserted normally.
